mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between the IF stage (instruction fetch, read-only)
//  and the MEM stage (data load/store). Sequences each access over a req/ack port and returns read data.
//  Drives freeze_if / freeze_mem, which the pipeline uses to hold IF, IF_Reg and the later stages while an access is pending.
// PARAMETERS
//  ADDR_W   32   address width (byte address, passed through unchanged)
//  DATA_W   32   data width
//  TIMEOUT  255  max cycles in BUSY without sram_ack (used only with MEM_ARB_TIMEOUT_EN); must be >=1
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  if_req      in   1       fetch request; held until if_ready
//  if_addr     in   ADDR_W  fetch address (PC)
//  if_rdata    out  DATA_W  fetched instruction, valid while if_ready=1
//  if_ready    out  1       one-cycle completion pulse for IF
//  mem_rd_req  in   1       data load request; held until mem_ready
//  mem_wr_req  in   1       data store request; held until mem_ready (never together with mem_rd_req)
//  mem_addr    in   ADDR_W  data address (ALU result)
//  mem_wdata   in   DATA_W  store data (Val_Rm)
//  mem_rdata   out  DATA_W  load data, valid while mem_ready=1
//  mem_ready   out  1       one-cycle completion pulse for MEM
//  freeze_if   out  1       comb: if_req & ~if_ready
//  freeze_mem  out  1       comb: (mem_rd_req|mem_wr_req) & ~mem_ready
//  sram_req    out  1       registered; high for the whole BUSY phase
//  sram_we     out  1       registered; 1 = write
//  sram_addr   out  ADDR_W  registered; stable while sram_req=1
//  sram_wdata  out  DATA_W  registered; stable while sram_req=1
//  sram_rdata  in   DATA_W  read data, sampled on the edge where sram_ack=1
//  sram_ack    in   1       completion; may arrive in the first BUSY cycle
//  err         out  1       sticky timeout flag (tied 0 without MEM_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Reset: state IDLE; sram_req, sram_we, if_ready, mem_ready, err = 0; sram_addr, sram_wdata, if_rdata, mem_rdata = 0.
//  - FSM: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM.
//  - IDLE: if mem_rd_req|mem_wr_req -> BUSY_MEM (latch mem_addr/mem_wdata, sram_we=mem_wr_req);
//    else if if_req -> BUSY_IF (latch if_addr, sram_we=0); else stay.
//    MEM has fixed priority over IF on the same cycle: it is the older instruction, and one MEM access per instruction bounds IF starvation.
//  - BUSY_x: sram_req=1 with stable outputs; on the edge sram_ack=1: sram_req<=0, capture sram_rdata into x_rdata (reads only),
//    go DONE_x. A write leaves mem_rdata unchanged.
//  - DONE_x: x_ready=1 for exactly this cycle; next state IDLE unconditionally. No re-arbitration in DONE.
//  - Latency: request seen in IDLE (cycle 0), sram_req cycles 1..n, ready in cycle n+1, IDLE in n+2. Zero-wait memory gives 1 access per 3 cycles.
//  - Request dropped mid-BUSY (protocol violation): the access still completes and the ready pulse is still issued.
//  - sram_ack outside BUSY: ignored.
//  - rst asserted mid-access: immediate return to IDLE; sram_req drops asynchronously; the access is abandoned with no ready pulse.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined: a cycle counter clears on entry to BUSY_x and increments each BUSY cycle.
//    At count==TIMEOUT with no ack: sram_req<=0, x_rdata<=0, err<=1 (sticky until rst), go DONE_x (ready still pulses).
//  Not defined: no counter; BUSY waits indefinitely for sram_ack; err is constant 0.
// STRUCTURE
//  Package arm_defs: mem_arb_state_t enum (5 states), MEM_ARB_TIMEOUT_DFLT=255.
//  Sub-module mem_arb_timer (clk, rst, clr, en -> expired), instantiated only under MEM_ARB_TIMEOUT_EN.
//  The FSM and datapath registers stay in mem_arbiter.
// TESTING
//  1 IF read, ack in first BUSY cycle: if_req, if_addr=0x10, rdata=0xE3A00001 -> sram_req cycle 1, if_ready+if_rdata=0xE3A00001 cycle 2.
//  2 Same-cycle if_req and mem_rd_req @0x100 -> MEM served first (sram_addr=0x100), then IF; freeze_if high throughout the MEM access.
//  3 Store mem_wr_req, addr=0x20, wdata=0x5A5A5A5A, ack after 4 cycles -> sram_we=1, data stable 4 cycles,
//    mem_ready pulse once, mem_rdata unchanged.
//  4 rst pulse while BUSY_MEM -> sram_req=0 the same cycle, no mem_ready, FSM IDLE; next request proceeds normally.
//  5 MEM_ARB_TIMEOUT_EN, TIMEOUT=8, ack never arrives -> sram_req drops after 8 BUSY cycles, ready pulses with rdata 0,
//    err=1 and stays 1 until rst.
//  6 Back-to-back IF requests, zero-wait memory -> if_ready every 3rd cycle; freeze_if low only in the ready cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module : arm_defs (package)
// Brief  : Shared state encoding and defaults for the IF/MEM memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_defs;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUSY_IF  = 3'd1,
        ST_BUSY_MEM = 3'd2,
        ST_DONE_IF  = 3'd3,
        ST_DONE_MEM = 3'd4
    } mem_arb_state_t;

    localparam int MEM_ARB_TIMEOUT_DFLT = 255;

endpackage

`default_nettype wire

// File: rtl/mem_arb_timer.sv
// ============================================================================
// Module : mem_arb_timer
// Brief  : BUSY-phase watchdog; expired is high in the TIMEOUT-th enabled cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds the number of BUSY cycles already elapsed before this one
    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Shares one req/ack memory between IF (fetch) and MEM (load/store).
//          Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import arm_defs::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = MEM_ARB_TIMEOUT_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              freeze_if,
    output logic              freeze_mem,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ack,
    output logic              err
);

    mem_arb_state_t    state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              err_q, err_d;
    logic              w_busy;
    logic              w_expired;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be >= 1");
    end

    assign w_busy = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_MEM);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!w_busy),
        .en      (w_busy),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                // MEM holds the older instruction, so it wins a same-cycle tie
                if (mem_rd_req || mem_wr_req) begin
                    state_d = ST_BUSY_MEM;
                    req_d   = 1'b1;
                    we_d    = mem_wr_req;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                end else if (if_req) begin
                    state_d = ST_BUSY_IF;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                end
            end
            ST_BUSY_IF: begin
                if (sram_ack) begin
                    state_d    = ST_DONE_IF;
                    req_d      = 1'b0;
                    if_rdata_d = sram_rdata;
                end else if (w_expired) begin
                    state_d    = ST_DONE_IF;
                    req_d      = 1'b0;
                    if_rdata_d = '0;
                    err_d      = 1'b1;
                end
            end
            ST_BUSY_MEM: begin
                if (sram_ack) begin
                    state_d = ST_DONE_MEM;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        mem_rdata_d = sram_rdata;
                    end
                end else if (w_expired) begin
                    state_d     = ST_DONE_MEM;
                    req_d       = 1'b0;
                    mem_rdata_d = '0;
                    err_d       = 1'b1;
                end
            end
            ST_DONE_IF, ST_DONE_MEM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            err_q       <= err_d;
        end
    end

    assign if_ready   = (state_q == ST_DONE_IF);
    assign mem_ready  = (state_q == ST_DONE_MEM);
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign freeze_if  = if_req && !if_ready;
    assign freeze_mem = (mem_rd_req || mem_wr_req) && !mem_ready;
    assign sram_req   = req_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module : tb_mem_arbiter
// Brief  : Self-checking bench for mem_arbiter with a scoreboard of ready results.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        freeze_if;
    logic        freeze_mem;
    logic        sram_req;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ack;
    logic        err;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .freeze_if  (freeze_if),
        .freeze_mem (freeze_mem),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ack   (sram_ack),
        .err        (err)
    );

    typedef struct {
        bit          is_mem;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          ready_pulses = 0;
    bit          resp_en = 1'b1;
    int          ack_delay = 0;
    logic [31:0] exp_mem_last = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after ack_delay extra BUSY cycles, writes land on the ack edge
    initial begin : responder
        int wait_cnt;
        wait_cnt   = 0;
        sram_ack   = 1'b0;
        sram_rdata = 32'h0;
        forever begin
            @(negedge clk);
            sram_ack = 1'b0;
            if (sram_req && resp_en) begin
                if (wait_cnt >= ack_delay) begin
                    sram_ack = 1'b1;
                    if (sram_we) begin
                        model[sram_addr] = sram_wdata;
                        sram_rdata = 32'hFFFF_FFFF;
                    end else begin
                        sram_rdata = model.exists(sram_addr) ? model[sram_addr] : 32'hDEAD_BEEF;
                    end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : monitor
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            if (if_ready || mem_ready) begin
                ready_pulses++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready: if_ready=%b mem_ready=%b, required no pulse", if_ready, mem_ready);
                end else begin
                    e = sb.pop_front();
                    got = mem_ready ? mem_rdata : if_rdata;
                    if (if_ready && mem_ready) begin
                        errors++;
                        $display("FAIL both_ready: if_ready=1 mem_ready=1, required one pulse");
                    end else if (e.is_mem != mem_ready) begin
                        errors++;
                        $display("FAIL ready_port: mem_ready=%b, required %b", mem_ready, e.is_mem);
                    end else if (got !== e.rdata) begin
                        errors++;
                        $display("FAIL ready_rdata: got %h, required %h", got, e.rdata);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rst        = 1'b1;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({sram_req, sram_we, if_ready, mem_ready, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/ifr/memr/err=%b, required 00000",
                     {sram_req, sram_we, if_ready, mem_ready, err});
        end
        checks++;
        if (sram_addr !== 32'h0 || sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_sram_bus: addr=%h wdata=%h, required 0", sram_addr, sram_wdata);
        end
        checks++;
        if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: if=%h mem=%h, required 0", if_rdata, mem_rdata);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sram_req !== 1'b0 || freeze_if !== 1'b0 || freeze_mem !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: sram_req=%b frz_if=%b frz_mem=%b, required 0", sram_req, freeze_if, freeze_mem);
        end
    endtask

    task automatic test_if_read;
        model[32'h10] = 32'hE3A0_0001;
        ack_delay = 0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h10;
        sb.push_back('{1'b0, 32'hE3A0_0001});
        @(negedge clk);
        checks++;
        if (sram_req !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 32'h10 || if_ready !== 1'b0 || freeze_if !== 1'b1) begin
            errors++;
            $display("FAIL if_busy_cycle1: req=%b we=%b addr=%h rdy=%b frz=%b, required 1 0 00000010 0 1",
                     sram_req, sram_we, sram_addr, if_ready, freeze_if);
        end
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b1 || sram_req !== 1'b0 || freeze_if !== 1'b0) begin
            errors++;
            $display("FAIL if_ready_cycle2: rdy=%b req=%b frz=%b, required 1 0 0", if_ready, sram_req, freeze_if);
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_ready !== 1'b0 || sram_req !== 1'b0) begin
            errors++;
            $display("FAIL if_back_idle: rdy=%b req=%b, required 0 0", if_ready, sram_req);
        end
    endtask

    task automatic test_priority;
        logic [31:0] first_addr;
        bit          seen_first;
        bit          saw_if;
        bit          got_if;
        int          frz_bad;
        model[32'h100] = 32'h1111_2222;
        model[32'h14]  = 32'h3333_4444;
        ack_delay  = 1;
        seen_first = 1'b0;
        saw_if     = 1'b0;
        got_if     = 1'b0;
        frz_bad    = 0;
        first_addr = 32'h0;
        @(negedge clk);
        if_req     = 1'b1;
        if_addr    = 32'h14;
        mem_rd_req = 1'b1;
        mem_addr   = 32'h100;
        sb.push_back('{1'b1, 32'h1111_2222});
        sb.push_back('{1'b0, 32'h3333_4444});
        exp_mem_last = 32'h1111_2222;
        for (int c = 0; c < 30 && !got_if; c++) begin
            @(negedge clk);
            if (sram_req && !seen_first) begin
                seen_first = 1'b1;
                first_addr = sram_addr;
            end
            if (sram_req && sram_addr == 32'h14) saw_if = 1'b1;
            if (mem_ready) mem_rd_req = 1'b0;
            if (if_ready) begin
                got_if = 1'b1;
                if_req = 1'b0;
            end else if (freeze_if !== 1'b1) begin
                frz_bad++;
            end
        end
        checks++;
        if (first_addr !== 32'h100) begin
            errors++;
            $display("FAIL prio_first_addr: got %h, required 00000100", first_addr);
        end
        checks++;
        if (!saw_if || !got_if) begin
            errors++;
            $display("FAIL prio_if_served: saw_addr=%b ready=%b, required 1 1", saw_if, got_if);
        end
        checks++;
        if (frz_bad != 0) begin
            errors++;
            $display("FAIL prio_freeze_if: low in %0d cycles, required 0", frz_bad);
        end
    endtask

    task automatic test_store;
        int stable;
        int pulses0;
        bit got;
        ack_delay = 3;
        stable    = 0;
        got       = 1'b0;
        pulses0   = ready_pulses;
        @(negedge clk);
        mem_wr_req = 1'b1;
        mem_addr   = 32'h20;
        mem_wdata  = 32'h5A5A_5A5A;
        sb.push_back('{1'b1, exp_mem_last});
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (sram_req && sram_we === 1'b1 && sram_addr === 32'h20 && sram_wdata === 32'h5A5A_5A5A) stable++;
            if (mem_ready) begin
                got = 1'b1;
                mem_wr_req = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (stable != 4) begin
            errors++;
            $display("FAIL store_stable_cycles: got %0d, required 4", stable);
        end
        checks++;
        if (ready_pulses - pulses0 != 1) begin
            errors++;
            $display("FAIL store_ready_pulses: got %0d, required 1", ready_pulses - pulses0);
        end
        checks++;
        if (!model.exists(32'h20) || model[32'h20] !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL store_written: memory not updated with 5a5a5a5a");
        end
        checks++;
        if (mem_rdata !== exp_mem_last) begin
            errors++;
            $display("FAIL store_rdata_kept: got %h, required %h", mem_rdata, exp_mem_last);
        end
    endtask

    task automatic test_rst_mid;
        int pulses0;
        bit got;
        resp_en = 1'b0;
        got     = 1'b0;
        @(negedge clk);
        mem_rd_req = 1'b1;
        mem_addr   = 32'h40;
        repeat (3) @(negedge clk);
        checks++;
        if (sram_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: sram_req=%b, required 1", sram_req);
        end
        pulses0 = ready_pulses;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sram_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_drop: sram_req=%b, required 0", sram_req);
        end
        mem_rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_mem_last = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (sram_req !== 1'b0 || mem_ready !== 1'b0 || ready_pulses != pulses0) begin
            errors++;
            $display("FAIL rst_abandon: req=%b rdy=%b pulses=%0d, required 0 0 0",
                     sram_req, mem_ready, ready_pulses - pulses0);
        end
        resp_en   = 1'b1;
        ack_delay = 0;
        model[32'h44] = 32'hCAFE_F00D;
        mem_rd_req = 1'b1;
        mem_addr   = 32'h44;
        sb.push_back('{1'b1, 32'hCAFE_F00D});
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1'b1;
                mem_rd_req = 1'b0;
            end
        end
        exp_mem_last = 32'hCAFE_F00D;
        checks++;
        if (!got || ready_pulses - pulses0 != 1) begin
            errors++;
            $display("FAIL rst_recover: ready=%b pulses=%0d, required 1 1", got, ready_pulses - pulses0);
        end
    endtask

    task automatic test_timeout;
        int busy;
        bit got;
        int pulses0;
        busy    = 0;
        got     = 1'b0;
        pulses0 = ready_pulses;
        resp_en = 1'b0;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h50;
`ifdef MEM_ARB_TIMEOUT_EN
        sb.push_back('{1'b0, 32'h0});
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (sram_req) busy++;
            if (if_ready) begin
                got = 1'b1;
                if_req = 1'b0;
            end
        end
        checks++;
        if (!got || busy != 8) begin
            errors++;
            $display("FAIL timeout_busy_cycles: ready=%b busy=%0d, required 1 8", got, busy);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_set: err=%b, required 1", err);
        end
        resp_en = 1'b1;
        got     = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h10;
        sb.push_back('{1'b0, 32'hE3A0_0001});
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (if_ready) begin
                got = 1'b1;
                if_req = 1'b0;
            end
        end
        checks++;
        if (!got || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err_sticky: ready=%b err=%b, required 1 1", got, err);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_mem_last = 32'h0;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear: err=%b, required 0", err);
        end
`else
        repeat (20) @(negedge clk);
        checks++;
        if (sram_req !== 1'b1 || err !== 1'b0 || ready_pulses != pulses0) begin
            errors++;
            $display("FAIL no_timeout_wait: req=%b err=%b pulses=%0d, required 1 0 0",
                     sram_req, err, ready_pulses - pulses0);
        end
        model[32'h50] = 32'h0BAD_F00D;
        sb.push_back('{1'b0, 32'h0BAD_F00D});
        resp_en = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (if_ready) begin
                got = 1'b1;
                if_req = 1'b0;
            end
        end
        checks++;
        if (!got || err !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_late_ack: ready=%b err=%b, required 1 0", got, err);
        end
`endif
        busy = busy;
    endtask

    task automatic test_back_to_back;
        int cyc;
        int last;
        int nready;
        int gap_bad;
        int frz_bad;
        cyc     = 0;
        last    = -1;
        nready  = 0;
        gap_bad = 0;
        frz_bad = 0;
        ack_delay = 0;
        for (int k = 0; k < 4; k++) begin
            model[32'h200 + 32'(4 * k)] = 32'hA000_0000 + 32'(k);
            sb.push_back('{1'b0, 32'hA000_0000 + 32'(k)});
        end
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 32'h200;
        for (int c = 0; c < 40 && nready < 4; c++) begin
            @(negedge clk);
            cyc++;
            if (freeze_if !== !if_ready) frz_bad++;
            if (if_ready) begin
                if (last >= 0 && cyc - last != 3) gap_bad++;
                last = cyc;
                nready++;
                if (nready < 4) if_addr = 32'h200 + 32'(4 * nready);
                else if_req = 1'b0;
            end
        end
        checks++;
        if (nready != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d readies, required 4", nready);
        end
        checks++;
        if (gap_bad != 0) begin
            errors++;
            $display("FAIL b2b_spacing: %0d gaps not 3 cycles, required 0", gap_bad);
        end
        checks++;
        if (frz_bad != 0) begin
            errors++;
            $display("FAIL b2b_freeze_if: %0d cycles wrong, required 0", frz_bad);
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_priority();
        test_store();
        test_rst_mid();
        test_timeout();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
